// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,  // no request outstanding
    WAIT  = 2'd1,  // one request outstanding, response will be buffered
    DRAIN = 2'd2   // one request outstanding, response is wrong-path and dropped
  } fetch_state_e;

  // Buffered instruction with its PC (32-bit address form; the top builds a
  // width-matched struct with the same layout for other ADDR_WIDTH values).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries for decode.
// Latency: 1 cycle push-to-visible; read data is the head entry, combinational.
// Backpressure: push ignored when full, pop ignored when empty; flush clears next cycle.
// Ports: clk, rst (sync, active-high), flush, push_vld/push_dat, pop,
//        rd_dat (head entry), count (current occupancy).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = fetch_entry_t,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_vld,
  input  T                 push_dat,
  input  logic             pop,
  output T                 rd_dat,
  output logic [CNT_W-1:0] count
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_vld && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem_q[wr_ptr_q] <= push_dat;
  end

  assign rd_dat = mem_q[rd_ptr_q];
  assign count  = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one word request at a time to imem, buffers
//   responses with their PC and presents them to decode; redirects flush wrong-path work.
// Latency: >=2 cycles per word with a 1-cycle imem; first target request the cycle after redirect.
// Backpressure: decode stalls fill the buffer; a full buffer stops issuing new requests.
// Ports: clk, rst (sync, active-high); imem_req_valid/ready/addr; imem_rsp_valid/data;
//   redirect/redirect_pc; instr_valid/ready, instr, instr_pc.
// Optional: FETCH_PERF_CNT_EN adds saturating perf_stall_cnt / perf_flush_cnt outputs.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  // Same layout as fetch_entry_t, sized to this instance's address width.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
  } entry_t;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [CNT_W-1:0]      fifo_count;
  entry_t                fifo_rd, push_ent;
  logic                  req_fire, fifo_push, fifo_pop;

  assign imem_req_valid = (state_q == RUN) && (fifo_count < CNT_W'(FIFO_DEPTH))
                          && !redirect && !rst;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A redirect kills any same-cycle response and overrides push/pop via flush.
  assign fifo_push = (state_q == WAIT) && imem_rsp_valid && !redirect;
  assign instr_valid = (fifo_count != '0) && !rst;
  assign fifo_pop    = instr_valid && instr_ready;
  assign push_ent    = '{pc: req_pc_q, instr: imem_rsp_data};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~ADDR_WIDTH'(3);
      // An outstanding request keeps us in DRAIN until its response shows up.
      if (state_q != RUN) state_d = imem_rsp_valid ? RUN : DRAIN;
    end else begin
      case (state_q)
        RUN: begin
          if (req_fire) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
            state_d    = WAIT;
          end
        end
        WAIT, DRAIN: begin
          if (imem_rsp_valid) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push_vld (fifo_push),
    .push_dat (push_ent),
    .pop      (fifo_pop),
    .rd_dat   (fifo_rd),
    .count    (fifo_count)
  );

  assign instr    = fifo_rd.instr;
  assign instr_pc = fifo_rd.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q;
    perf_flush_cnt_d = perf_flush_cnt_q;
    if (instr_ready && !instr_valid && (perf_stall_cnt_q != '1))
      perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    if (redirect && (perf_flush_cnt_q != '1))
      perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small in-order imem model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_n  = 0;

  // imem model state
  int          rsp_delay = 1;
  logic        pend      = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt  = 0;

  logic [31:0] pop_pc [$];
  logic [31:0] pop_ins[$];
  int          pop_cyc[$];
  logic [31:0] acc_q  [$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // One clock: log handshakes at the falling edge, then update the imem model
  // 1 time unit after the rising edge.
  task automatic cyc();
    logic        acc;
    logic [31:0] a;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    if (instr_valid && instr_ready && !redirect) begin
      pop_pc.push_back(instr_pc);
      pop_ins.push_back(instr);
      pop_cyc.push_back(cyc_n);
    end
    if (acc) acc_q.push_back(a);
    @(posedge clk);
    #1;
    cyc_n++;
    imem_rsp_valid = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (acc) begin
        pend      = 1'b1;
        pend_addr = a;
        pend_cnt  = rsp_delay;
      end
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = word(pend_addr);
          pend           = 1'b0;
        end
      end
    end
  endtask

  task automatic clear_logs();
    pop_pc.delete();
    pop_ins.delete();
    pop_cyc.delete();
    acc_q.delete();
  endtask

  task automatic do_reset(input string tag);
    rst      = 1'b1;
    redirect = 1'b0;
    cyc();
    cyc();
    #2;
    check({tag, "_rst_ivld"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_rst_rvld"}, {31'd0, imem_req_valid}, 32'd0);
    check({tag, "_rst_pc"}, imem_req_addr, 32'h0);
    rst   = 1'b0;
    cyc_n = 0;
    clear_logs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;

    // 1: steady fetch, one instruction every 2 cycles
    rsp_delay = 1;
    do_reset("t1");
    repeat (7) cyc();
    check("t1_npop", 32'(pop_pc.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < pop_pc.size()) begin
        check("t1_pc", pop_pc[i], 32'(4 * i));
        check("t1_ins", pop_ins[i], word(32'(4 * i)));
      end
    end
    if (pop_cyc.size() >= 3) begin
      check("t1_gap0", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
      check("t1_gap1", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);
    end

    // 2: decode stall fills the buffer, then drains in order
    instr_ready = 1'b0;
    do_reset("t2");
    repeat (10) cyc();
    #2;
    check("t2_full_rvld", {31'd0, imem_req_valid}, 32'd0);
    check("t2_full_ivld", {31'd0, instr_valid}, 32'd1);
    check("t2_full_pc", instr_pc, 32'h0);
    check("t2_nacc", 32'(acc_q.size()), 32'd2);
    instr_ready = 1'b1;
    repeat (8) cyc();
    check("t2_npop", 32'(pop_pc.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < pop_pc.size()) check("t2_pc", pop_pc[i], 32'(4 * i));
    end
    if (acc_q.size() >= 3) check("t2_resume", acc_q[2], 32'h8);

    // 3: redirect while WAIT, wrong-path response arrives 2 cycles later
    instr_ready = 1'b0;
    rsp_delay   = 1;
    do_reset("t3");
    cyc();
    cyc();
    rsp_delay = 3;
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    rsp_delay   = 1;
    clear_logs();
    #2;
    check("t3_redir_rvld", {31'd0, imem_req_valid}, 32'd0);
    cyc();
    redirect = 1'b0;
    #2;
    check("t3_flush_ivld", {31'd0, instr_valid}, 32'd0);
    instr_ready = 1'b1;
    repeat (6) cyc();
    check("t3_npop", 32'(pop_pc.size()), 32'd1);
    if (pop_pc.size() > 0) begin
      check("t3_pc", pop_pc[0], 32'h100);
      check("t3_ins", pop_ins[0], word(32'h100));
    end
    if (acc_q.size() > 0) check("t3_acc", acc_q[0], 32'h100);

    // 4: redirect coincides with response and pop
    instr_ready = 1'b0;
    rsp_delay   = 1;
    do_reset("t4");
    repeat (3) cyc();
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    clear_logs();
    #2;
    check("t4_pre_ivld", {31'd0, instr_valid}, 32'd1);
    cyc();
    redirect = 1'b0;
    #2;
    check("t4_ivld", {31'd0, instr_valid}, 32'd0);
    check("t4_rvld", {31'd0, imem_req_valid}, 32'd1);
    check("t4_addr", imem_req_addr, 32'h200);
    repeat (4) cyc();
    check("t4_npop", 32'(pop_pc.size()), 32'd1);
    if (pop_pc.size() > 0) check("t4_pc", pop_pc[0], 32'h200);

    // 5: imem not ready holds the address; reset mid-run
    instr_ready    = 1'b1;
    imem_req_ready = 1'b0;
    do_reset("t5");
    for (int i = 0; i < 5; i++) begin
      cyc();
      #2;
      check("t5_hold_addr", imem_req_addr, 32'h0);
    end
    check("t5_nacc", 32'(acc_q.size()), 32'd0);
    imem_req_ready = 1'b1;
    repeat (4) cyc();
    check("t5_adv_addr", imem_req_addr, 32'h8);
    rst = 1'b1;
    cyc();
    #2;
    check("t5_mid_ivld", {31'd0, instr_valid}, 32'd0);
    check("t5_mid_pc", imem_req_addr, 32'h0);
    rst = 1'b0;
    clear_logs();
    repeat (2) cyc();
    if (acc_q.size() > 0) check("t5_post_acc", acc_q[0], 32'h0);
    else check("t5_post_nacc", 32'(acc_q.size()), 32'd1);

`ifdef FETCH_PERF_CNT_EN
    // 6: 3 stall cycles and a 2-cycle redirect
    instr_ready    = 1'b0;
    imem_req_ready = 1'b0;
    do_reset("t6");
    #2;
    check("t6_stall0", perf_stall_cnt, 32'd0);
    instr_ready = 1'b1;
    repeat (3) cyc();
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    repeat (2) cyc();
    redirect = 1'b0;
    cyc();
    #2;
    check("t6_stall", perf_stall_cnt, 32'd3);
    check("t6_flush", perf_flush_cnt, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
